// File: rtl/binary_down_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : binary_down_counter_pkg
// Description : Shared constants for the loadable down-counter timer:
//               control-state encodings and the default counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package binary_down_counter_pkg;

    // Control FSM encodings (explicit 2-bit width)
    localparam logic [1:0] c_IDLE = 2'b00;  // nothing loaded
    localparam logic [1:0] c_RUN  = 2'b01;  // counting toward zero
    localparam logic [1:0] c_DONE = 2'b10;  // one-shot has expired

    // Default counter width
    localparam int c_DEFAULT_WIDTH = 8;

endpackage : binary_down_counter_pkg
`default_nettype wire

// File: rtl/binary_down_counter_t_flip_flop.sv
`default_nettype none
// ============================================================================
// Module      : t_flip_flop
// Description : Single toggle flip-flop cell. The output inverts on every
//               clock edge where t is high. Reset is synchronous and clears
//               q to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module t_flip_flop (
    input  logic clock,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic r_q;

    // Toggle storage: reset clears the cell, otherwise invert when t is set
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= 1'b0;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

endmodule : t_flip_flop
`default_nettype wire

// File: rtl/binary_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : binary_down_counter
// Description : Loadable synchronous down-counter used as a programmable
//               interval timer. Counts a loaded value down to zero, emits a
//               one-cycle terminal-count pulse and can optionally reload the
//               start value automatically. The count register is built from
//               toggle flip-flops driven by a synchronous borrow chain.
// Revision    : 1.0 - initial release
// ============================================================================
module binary_down_counter
    import binary_down_counter_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             toggle,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             reload,
    output logic [WIDTH-1:0] A,
    output logic             zero,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_reload_val;
    logic             r_zero;
    logic             r_tc;
    logic             r_busy;

    logic [WIDTH-1:0] w_q;        // current count from the flip-flop chain
    logic [WIDTH-1:0] w_t;        // per-bit toggle requests
    logic [WIDTH-1:0] w_borrow;   // high when every lower bit is zero
    logic [WIDTH-1:0] w_a_next;   // count value after this edge
    logic             w_step;     // a decrement is requested this cycle
    logic             w_terminal; // this decrement takes the count through 1

    assign w_step     = toggle && (r_state == c_RUN);
    assign w_terminal = w_step && (w_q == c_ONE);

    // Counter datapath: one toggle cell per bit plus the borrow chain
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bits
            if (i == 0) begin : g_borrow_lsb
                assign w_borrow[i] = 1'b1;
            end else begin : g_borrow_upper
                assign w_borrow[i] = w_borrow[i-1] & ~w_q[i-1];
            end

            t_flip_flop u_tff (
                .clock (clock),
                .reset (reset),
                .t     (w_t[i]),
                .q     (w_q[i])
            );
        end
    endgenerate

    // Toggle selection: load beats reload, reload beats a plain decrement.
    // Loading is expressed as "flip every bit that differs" from the target.
    always_comb begin
        w_t = '0;
        if (load) begin
            w_t = w_q ^ load_value;
        end else if (w_terminal && reload) begin
            w_t = w_q ^ r_reload_val;
        end else if (w_step) begin
            w_t = w_borrow;
        end
    end

    assign w_a_next = w_q ^ w_t;

    // Next-state decode for the control FSM
    always_comb begin
        w_state_next = r_state;
        if (load) begin
            w_state_next = (load_value != '0) ? c_RUN : c_IDLE;
        end else if (w_terminal && !reload) begin
            w_state_next = c_DONE;
        end
    end

    // Control state, reload value and registered status flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_reload_val <= '0;
            r_zero       <= 1'b1;
            r_tc         <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (load) begin
                r_reload_val <= load_value;
            end
            // zero tracks the value the counter takes on this same edge
            r_zero <= (w_a_next == '0);
            // a load on the terminal edge suppresses the pulse
            r_tc   <= w_terminal && !load;
            r_busy <= (w_state_next == c_RUN);
        end
    end

    assign A    = w_q;
    assign zero = r_zero;
    assign tc   = r_tc;
    assign busy = r_busy;

endmodule : binary_down_counter
`default_nettype wire

// File: tb/tb_binary_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_binary_down_counter
// Description : Self-checking bench for binary_down_counter. A timer model
//               kept here predicts A/zero/tc/busy each cycle; directed
//               scenarios add hand-computed literal expectations and a
//               randomized phase exercises mixed load/reset/toggle traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_binary_down_counter;

    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             toggle = 1'b0;
    logic             load = 1'b0;
    logic             reload = 1'b0;
    logic [WIDTH-1:0] load_value = '0;
    logic [WIDTH-1:0] A;
    logic             zero;
    logic             tc;
    logic             busy;

    int n_pass  = 0;
    int n_total = 0;
    bit check_en = 1'b0;

    // Model of the timer: mode 0 = idle, 1 = running, 2 = expired
    int         m_mode   = 0;
    logic [7:0] m_a      = '0;
    logic [7:0] m_reload = '0;
    bit         m_tc     = 1'b0;

    int tc_count;

    binary_down_counter #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .toggle     (toggle),
        .load       (load),
        .load_value (load_value),
        .reload     (reload),
        .A          (A),
        .zero       (zero),
        .tc         (tc),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    function automatic void check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endfunction

    // Advance the model by one clock edge using the inputs applied to it
    function automatic void model_step();
        if (reset) begin
            m_a = 0; m_reload = 0; m_mode = 0; m_tc = 0;
        end else if (load) begin
            m_a = load_value; m_reload = load_value; m_tc = 0;
            m_mode = (load_value != 0) ? 1 : 0;
        end else if (m_mode == 1 && toggle) begin
            if (m_a == 1) begin
                m_tc = 1;
                if (reload) m_a = m_reload;
                else begin m_a = 0; m_mode = 2; end
            end else begin
                m_a = m_a - 1;
                m_tc = 0;
            end
        end else begin
            m_tc = 0;
        end
    endfunction

    // Apply one cycle of inputs, let the edge happen, update the model
    task automatic cyc(input bit r, input bit t, input bit l, input bit rl, input logic [7:0] lv);
        reset = r; toggle = t; load = l; reload = rl; load_value = lv;
        @(posedge clock);
        model_step();
        #1;
    endtask

    // Continuous comparison against the model on the falling edge
    always @(negedge clock) begin
        if (check_en) begin
            check("A",    int'(A),    int'(m_a));
            check("zero", int'(zero), int'(m_a == 0));
            check("tc",   int'(tc),   int'(m_tc));
            check("busy", int'(busy), int'(m_mode == 1));
        end
    end

    initial begin
        int exp_seq [5];
        exp_seq = '{4, 3, 2, 1, 0};

        // T1: reset, load 5, count to zero, then hold
        cyc(1, 0, 0, 0, 8'h00);
        check_en = 1'b1;
        check("reset_A",    int'(A),    0);
        check("reset_zero", int'(zero), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_tc",   int'(tc),   0);
        cyc(0, 0, 1, 0, 8'd5);
        check("t1_load_A", int'(A), 5);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, 0, 0, 8'h00);
            check("t1_seq_A",  int'(A),  exp_seq[k]);
            check("t1_seq_tc", int'(tc), (k == 4) ? 1 : 0);
        end
        check("t1_busy_after", int'(busy), 0);
        for (int k = 0; k < 10; k++) cyc(0, 1, 0, 0, 8'h00);
        check("t1_hold_A", int'(A), 0);

        // T2: auto-reload of 3
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 0, 1, 1, 8'd3);
        for (int k = 0; k < 9; k++) begin
            cyc(0, 1, 0, 1, 8'h00);
            check("t2_A",    int'(A),    (k % 3 == 0) ? 2 : (k % 3 == 1) ? 1 : 3);
            check("t2_tc",   int'(tc),   (k % 3 == 2) ? 1 : 0);
            check("t2_zero", int'(zero), 0);
        end

        // T3: pause mid-count, resume, then toggle in the expired state
        cyc(0, 0, 1, 0, 8'd8);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 8'h00);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 8'h00);
        check("t3_hold_A", int'(A), 5);
        for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 8'h00);
        check("t3_end_A",  int'(A),  0);
        check("t3_end_tc", int'(tc), 1);
        for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0, 8'h00);
        check("t3_done_A", int'(A), 0);

        // T4: loading zero returns to idle
        cyc(0, 0, 1, 0, 8'd0);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 8'h00);
        check("t4_A",    int'(A),    0);
        check("t4_zero", int'(zero), 1);
        check("t4_busy", int'(busy), 0);
        check("t4_tc",   int'(tc),   0);

        // T5: load on the terminal edge, then reset mid-count
        cyc(0, 0, 1, 0, 8'd2);
        cyc(0, 1, 0, 0, 8'h00);
        check("t5_pre_A", int'(A), 1);
        cyc(0, 1, 1, 0, 8'h22);
        check("t5_A",    int'(A),    8'h22);
        check("t5_tc",   int'(tc),   0);
        check("t5_busy", int'(busy), 1);
        for (int k = 0; k < 8'h12; k++) cyc(0, 1, 0, 0, 8'h00);
        check("t5_mid_A", int'(A), 8'h10);
        cyc(1, 1, 0, 0, 8'h00);
        check("t5_rst_A",    int'(A),    0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_tc",   int'(tc),   0);

        // T6: full-range count from 0xFF
        cyc(0, 0, 1, 0, 8'hFF);
        tc_count = 0;
        for (int k = 0; k < 260; k++) begin
            cyc(0, 1, 0, 0, 8'h00);
            if (tc) tc_count++;
            if (k == 253) check("t6_at1_A", int'(A), 1);
        end
        check("t6_tc_count", tc_count, 1);
        check("t6_end_A",    int'(A),  0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            bit r, t, l, rl;
            logic [7:0] lv;
            r  = ($urandom_range(0, 99) < 2);
            l  = ($urandom_range(0, 99) < 8);
            t  = ($urandom_range(0, 99) < 75);
            rl = ($urandom_range(0, 99) < 50);
            lv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 40));
            cyc(r, t, l, rl, lv);
        end

        @(posedge clock);
        #1;
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_binary_down_counter
`default_nettype wire
